// File: rtl/scene_memory_pkg.sv
// Shared types and constants for the scene memory.
// Defines the decoded-instruction format, the packed scene records (shape,
// light, camera), their word counts, table address types and the RMW FSM
// state type.
package scene_memory_pkg;

  localparam int unsigned NUM_SHAPES = 16;
  localparam int unsigned NUM_LIGHTS = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned RD_LAT     = 2;

  localparam int unsigned SHAPE_AW = $clog2(NUM_SHAPES);
  localparam int unsigned LIGHT_AW = $clog2(NUM_LIGHTS);
  localparam int unsigned INDEX_W  = 5;
  localparam int unsigned FIELD_W  = 3;

  typedef logic [SHAPE_AW-1:0] ShapeAddr;
  typedef logic [LIGHT_AW-1:0] LightAddr;

  typedef enum logic [2:0] {
    opNop, opFrame, opRender, opShapeWr, opLightWr, opCameraWr, opClear
  } iType_t;

  typedef struct packed {
    iType_t              iType;
    logic [INDEX_W-1:0]  index;
    logic [FIELD_W-1:0]  field;
    logic [WORD_W-1:0]   data;
  } DecodedInst;

  typedef struct packed {
    logic [31:0] pos_x;
    logic [31:0] pos_y;
    logic [31:0] pos_z;
    logic [31:0] radius;
    logic [7:0]  material;
  } Shape;

  typedef struct packed {
    logic [31:0] pos_x;
    logic [31:0] pos_y;
    logic [31:0] pos_z;
    logic [23:0] color;
  } Light;

  typedef struct packed {
    logic [31:0] pos_x;
    logic [31:0] pos_y;
    logic [31:0] pos_z;
    logic [31:0] dir_x;
    logic [31:0] dir_y;
    logic [31:0] dir_z;
  } Camera;

  localparam int unsigned SHAPE_W  = $bits(Shape);
  localparam int unsigned LIGHT_W  = $bits(Light);
  localparam int unsigned CAMERA_W = $bits(Camera);

  localparam int unsigned SHAPE_WORDS  = (SHAPE_W  + WORD_W - 1) / WORD_W;
  localparam int unsigned LIGHT_WORDS  = (LIGHT_W  + WORD_W - 1) / WORD_W;
  localparam int unsigned CAMERA_WORDS = (CAMERA_W + WORD_W - 1) / WORD_W;

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WAIT, RMW_WR} rmw_state_t;

endpackage

// File: rtl/scene_bram.sv
// One scene table: simple dual-port memory with registered address and
// registered output (2-cycle read), per-entry valid flops, and the
// read-modify-write FSM that merges a single word into an entry.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_start           accepted word write (index/field/data) this cycle
//   wr_index/field/data  word write target and payload
//   clr                clear every valid bit
//   rd_addr            read index; rd_data/rd_valid appear 2 cycles later
//   busy               request pending or RMW in progress
module scene_bram
  import scene_memory_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_start,
  input  logic [AW-1:0]      wr_index,
  input  logic [FIELD_W-1:0] wr_field,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic               clr,
  input  logic [AW-1:0]      rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic               busy
);

  localparam int unsigned WORDS = (WIDTH + WORD_W - 1) / WORD_W;
  localparam int unsigned PAD_W = WORDS * WORD_W;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  rmw_state_t         state_q, state_d;
  logic               req_q, req_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [FIELD_W-1:0] fld_q, fld_d;
  logic [WORD_W-1:0]  wdat_q, wdat_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [WIDTH-1:0]   dout_q;
  logic               vout_q;
  logic               mem_we;
  logic [PAD_W-1:0]   pad;
  logic [WIDTH-1:0]   merged;

  // The accepted write is held one cycle in req_q before the FSM leaves
  // IDLE, so busy covers the request cycle plus RD, WAIT and WR.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fld_d   = fld_q;
    wdat_d  = wdat_q;
    valid_d = valid_q;
    mem_we  = 1'b0;

    // Zero-pad the old entry to whole words, drop the new word in, and
    // truncate back so bits beyond the record width are discarded.
    pad = PAD_W'(dout_q);
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (fld_q == FIELD_W'(w)) pad[w*WORD_W +: WORD_W] = wdat_q;
    end
    merged = pad[WIDTH-1:0];

    if (wr_start) begin
      req_d  = 1'b1;
      idx_d  = wr_index;
      fld_d  = wr_field;
      wdat_d = wr_data;
    end

    case (state_q)
      IDLE: begin
        if (req_q) begin
          state_d = RMW_RD;
          req_d   = 1'b0;
        end
      end
      RMW_RD: begin
        state_d = RMW_WAIT;
        cnt_d   = '0;
      end
      RMW_WAIT: begin
        if (cnt_q == 2'(RD_LAT - 2)) state_d = RMW_WR;
        else cnt_d = cnt_q + 2'd1;
      end
      RMW_WR: begin
        mem_we         = 1'b1;
        valid_d[idx_q] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clr) valid_d = '0;

    addr_d = (state_q != IDLE) ? idx_q : rd_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Read-before-write: a read of the entry being committed returns old data.
  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    fld_q  <= fld_d;
    wdat_q <= wdat_d;
    addr_q <= addr_d;
    dout_q <= mem[addr_q];
    vout_q <= valid_q[addr_q];
    if (mem_we && !rst) mem[idx_q] <= merged;
  end

  assign rd_data  = dout_q;
  assign rd_valid = vout_q;
  assign busy     = req_q || (state_q != IDLE);

endmodule

// File: rtl/scene_memory.sv
// Scene description store for the raytracing controller.
// Shape and light tables live in scene_bram instances; the camera is a
// register. Word writes arrive on the executed-instruction stream; illegal
// or untimely writes are refused with a one-cycle write_err pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   execInst_valid/execInst  instruction stream (iType, index, field, data)
//   render_busy              refuses scene writes while high
//   cur_shape_addr/_light_addr  read indices
//   cur_shape/cur_light, shape_valid/light_valid  read data, 2 cycles later
//   cur_camera               camera register
//   mem_ready                reads coherent and a write can be accepted
//   write_err                pulse the cycle after a rejected write
module scene_memory
  import scene_memory_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       execInst_valid,
  input  DecodedInst execInst,
  input  logic       render_busy,
  input  ShapeAddr   cur_shape_addr,
  input  LightAddr   cur_light_addr,
  output Shape       cur_shape,
  output Light       cur_light,
  output logic       shape_valid,
  output logic       light_valid,
  output Camera      cur_camera,
  output logic       mem_ready,
  output logic       write_err
);

  localparam int unsigned CAM_PAD_W = CAMERA_WORDS * WORD_W;

  logic shape_busy, light_busy;
  logic shape_go, light_go, clr_go, cam_we, reject;
  logic write_err_q, write_err_d;
  Camera cam_q, cam_d;
  logic [CAM_PAD_W-1:0] cam_pad;

  assign mem_ready = !(shape_busy || light_busy);

  always_comb begin
    shape_go = 1'b0;
    light_go = 1'b0;
    clr_go   = 1'b0;
    cam_we   = 1'b0;
    reject   = 1'b0;
    if (execInst_valid) begin
      case (execInst.iType)
        opShapeWr:
          if (render_busy || !mem_ready || execInst.index >= INDEX_W'(NUM_SHAPES) ||
              execInst.field >= FIELD_W'(SHAPE_WORDS)) reject = 1'b1;
          else shape_go = 1'b1;
        opLightWr:
          if (render_busy || !mem_ready || execInst.index >= INDEX_W'(NUM_LIGHTS) ||
              execInst.field >= FIELD_W'(LIGHT_WORDS)) reject = 1'b1;
          else light_go = 1'b1;
        opCameraWr:
          if (render_busy || !mem_ready || execInst.field >= FIELD_W'(CAMERA_WORDS))
            reject = 1'b1;
          else cam_we = 1'b1;
        opClear:
          if (render_busy || !mem_ready) reject = 1'b1;
          else clr_go = 1'b1;
        default: ;
      endcase
    end
    write_err_d = reject;
  end

  always_comb begin
    cam_pad = CAM_PAD_W'(cam_q);
    if (cam_we) begin
      for (int unsigned w = 0; w < CAMERA_WORDS; w++) begin
        if (execInst.field == FIELD_W'(w)) cam_pad[w*WORD_W +: WORD_W] = execInst.data;
      end
    end
    cam_d = cam_pad[CAMERA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cam_q       <= '0;
      write_err_q <= 1'b0;
    end else begin
      cam_q       <= cam_d;
      write_err_q <= write_err_d;
    end
  end

  assign cur_camera = cam_q;
  assign write_err  = write_err_q;

  scene_bram #(.DEPTH(NUM_SHAPES), .WIDTH(SHAPE_W)) u_shape_bram (
    .clk      (clk),
    .rst      (rst),
    .wr_start (shape_go),
    .wr_index (execInst.index[SHAPE_AW-1:0]),
    .wr_field (execInst.field),
    .wr_data  (execInst.data),
    .clr      (clr_go),
    .rd_addr  (cur_shape_addr),
    .rd_data  (cur_shape),
    .rd_valid (shape_valid),
    .busy     (shape_busy)
  );

  scene_bram #(.DEPTH(NUM_LIGHTS), .WIDTH(LIGHT_W)) u_light_bram (
    .clk      (clk),
    .rst      (rst),
    .wr_start (light_go),
    .wr_index (execInst.index[LIGHT_AW-1:0]),
    .wr_field (execInst.field),
    .wr_data  (execInst.data),
    .clr      (clr_go),
    .rd_addr  (cur_light_addr),
    .rd_data  (cur_light),
    .rd_valid (light_valid),
    .busy     (light_busy)
  );

endmodule

// File: tb/tb_scene_memory.sv
// Scoreboard bench for scene_memory: a word-array reference model predicts
// mem_ready, write_err, camera and table reads; a negedge monitor compares.
module tb_scene_memory;
  import scene_memory_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, execInst_valid, render_busy;
  DecodedInst execInst;
  ShapeAddr   cur_shape_addr;
  LightAddr   cur_light_addr;
  Shape       cur_shape;
  Light       cur_light;
  logic       shape_valid, light_valid;
  Camera      cur_camera;
  logic       mem_ready, write_err;

  scene_memory dut (
    .clk(clk), .rst(rst), .execInst_valid(execInst_valid), .execInst(execInst),
    .render_busy(render_busy), .cur_shape_addr(cur_shape_addr), .cur_light_addr(cur_light_addr),
    .cur_shape(cur_shape), .cur_light(cur_light), .shape_valid(shape_valid),
    .light_valid(light_valid), .cur_camera(cur_camera), .mem_ready(mem_ready), .write_err(write_err)
  );

  typedef struct { int due; logic [191:0] d; logic [191:0] m; } item_t;
  item_t q_rdy[$], q_err[$], q_cam[$], q_sv[$], q_sd[$], q_lv[$], q_ld[$];

  int cyc = 0;
  int n_checks = 0, n_pass = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: tables as arrays of words with per-word "known" flags.
  logic [31:0] sh_w [NUM_SHAPES][SHAPE_WORDS];
  bit          sh_k [NUM_SHAPES][SHAPE_WORDS];
  bit          sh_v [NUM_SHAPES];
  logic [31:0] li_w [NUM_LIGHTS][LIGHT_WORDS];
  bit          li_k [NUM_LIGHTS][LIGHT_WORDS];
  bit          li_v [NUM_LIGHTS];
  logic [31:0] cam_w [CAMERA_WORDS];
  int sh_busy = 0, li_busy = 0;
  bit sh_pend = 0, li_pend = 0;
  int sh_pi, sh_pf, li_pi, li_pf;
  logic [31:0] sh_pd, li_pd;
  bit known = 0;

  function automatic logic [191:0] lowmask(input int n);
    return (192'(1) << n) - 192'(1);
  endfunction

  function automatic logic [191:0] flat_sh(input int i);
    logic [191:0] v = '0;
    for (int w = 0; w < SHAPE_WORDS; w++) v |= 192'(sh_w[i][w]) << (w * WORD_W);
    return v;
  endfunction

  function automatic logic [191:0] mask_sh(input int i);
    logic [191:0] m = '0;
    for (int w = 0; w < SHAPE_WORDS; w++) if (sh_k[i][w]) m |= 192'(32'hFFFF_FFFF) << (w * WORD_W);
    return m & lowmask(SHAPE_W);
  endfunction

  function automatic logic [191:0] flat_li(input int i);
    logic [191:0] v = '0;
    for (int w = 0; w < LIGHT_WORDS; w++) v |= 192'(li_w[i][w]) << (w * WORD_W);
    return v;
  endfunction

  function automatic logic [191:0] mask_li(input int i);
    logic [191:0] m = '0;
    for (int w = 0; w < LIGHT_WORDS; w++) if (li_k[i][w]) m |= 192'(32'hFFFF_FFFF) << (w * WORD_W);
    return m & lowmask(LIGHT_W);
  endfunction

  function automatic logic [191:0] flat_cam();
    logic [191:0] v = '0;
    for (int w = 0; w < CAMERA_WORDS; w++) v |= 192'(cam_w[w]) << (w * WORD_W);
    return v;
  endfunction

  // One clock cycle of stimulus; the model is advanced and expectations queued.
  task automatic step(input bit v, input iType_t t, input int idx, input int fld,
                      input logic [31:0] d, input bit rb, input int sa, input int la, input bit r);
    bit ready, rej, acc_sh, acc_li;
    int sh_nx, li_nx;
    @(posedge clk); #1;
    if (sh_busy == 0 && sh_pend) begin
      sh_w[sh_pi][sh_pf] = sh_pd; sh_k[sh_pi][sh_pf] = 1; sh_v[sh_pi] = 1; sh_pend = 0;
    end
    if (li_busy == 0 && li_pend) begin
      li_w[li_pi][li_pf] = li_pd; li_k[li_pi][li_pf] = 1; li_v[li_pi] = 1; li_pend = 0;
    end
    rst = r; execInst_valid = v; execInst.iType = t; execInst.index = 5'(idx);
    execInst.field = 3'(fld); execInst.data = d; render_busy = rb;
    cur_shape_addr = ShapeAddr'(sa); cur_light_addr = LightAddr'(la);

    ready = (sh_busy == 0 && li_busy == 0);
    if (known) begin
      q_rdy.push_back('{cyc, 192'(ready), 192'(1)});
      q_cam.push_back('{cyc, flat_cam(), lowmask(CAMERA_W)});
    end

    rej = 0; acc_sh = 0; acc_li = 0;
    if (v && !r) begin
      case (t)
        opShapeWr:  if (rb || !ready || idx >= NUM_SHAPES || fld >= SHAPE_WORDS) rej = 1; else acc_sh = 1;
        opLightWr:  if (rb || !ready || idx >= NUM_LIGHTS || fld >= LIGHT_WORDS) rej = 1; else acc_li = 1;
        opCameraWr: if (rb || !ready || fld >= CAMERA_WORDS) rej = 1; else cam_w[fld] = d;
        opClear: begin
          if (rb || !ready) rej = 1;
          else begin
            foreach (sh_v[i]) sh_v[i] = 0;
            foreach (li_v[i]) li_v[i] = 0;
          end
        end
        default: ;
      endcase
    end

    if (r) begin
      foreach (sh_v[i]) sh_v[i] = 0;
      foreach (li_v[i]) li_v[i] = 0;
      foreach (cam_w[i]) cam_w[i] = '0;
      sh_pend = 0; li_pend = 0; sh_nx = 0; li_nx = 0;
    end else begin
      sh_nx = acc_sh ? RD_LAT + 2 : (sh_busy > 0 ? sh_busy - 1 : 0);
      li_nx = acc_li ? RD_LAT + 2 : (li_busy > 0 ? li_busy - 1 : 0);
      if (acc_sh) begin sh_pend = 1; sh_pi = idx; sh_pf = fld; sh_pd = d; end
      if (acc_li) begin li_pend = 1; li_pi = idx; li_pf = fld; li_pd = d; end
    end

    if (known) begin
      q_err.push_back('{cyc + 1, 192'(rej), 192'(1)});
      if (sh_busy == 0 && sh_nx == 0) begin
        q_sv.push_back('{cyc + 2, 192'(sh_v[sa]), 192'(1)});
        q_sd.push_back('{cyc + 2, flat_sh(sa), mask_sh(sa)});
      end
      if (li_busy == 0 && li_nx == 0) begin
        q_lv.push_back('{cyc + 2, 192'(li_v[la]), 192'(1)});
        q_ld.push_back('{cyc + 2, flat_li(la), mask_li(la)});
      end
    end
    sh_busy = sh_nx; li_busy = li_nx;
    if (r) known = 1;
  endtask

  task automatic idle(input int sa, input int la);
    step(0, opNop, 0, 0, 32'h0, 0, sa, la, 0);
  endtask

  task automatic chk(input string nm, input logic [191:0] act, input item_t it);
    n_checks++;
    if (((act ^ it.d) & it.m) == '0) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act & it.m, it.d & it.m);
  endtask

  always @(negedge clk) begin : monitor
    item_t it;
    if (q_rdy.size() > 0 && q_rdy[0].due == cyc) begin it = q_rdy.pop_front(); chk("mem_ready", 192'(mem_ready), it); end
    if (q_err.size() > 0 && q_err[0].due == cyc) begin it = q_err.pop_front(); chk("write_err", 192'(write_err), it); end
    if (q_cam.size() > 0 && q_cam[0].due == cyc) begin it = q_cam.pop_front(); chk("cur_camera", 192'(cur_camera), it); end
    if (q_sv.size() > 0 && q_sv[0].due == cyc) begin it = q_sv.pop_front(); chk("shape_valid", 192'(shape_valid), it); end
    if (q_sd.size() > 0 && q_sd[0].due == cyc) begin it = q_sd.pop_front(); chk("cur_shape", 192'(cur_shape), it); end
    if (q_lv.size() > 0 && q_lv[0].due == cyc) begin it = q_lv.pop_front(); chk("light_valid", 192'(light_valid), it); end
    if (q_ld.size() > 0 && q_ld[0].due == cyc) begin it = q_ld.pop_front(); chk("cur_light", 192'(cur_light), it); end
  end

  initial begin
    int left;
    rst = 1; execInst_valid = 0; render_busy = 0; execInst = '0;
    cur_shape_addr = '0; cur_light_addr = '0;
    foreach (sh_k[i, w]) sh_k[i][w] = 0;
    foreach (li_k[i, w]) li_k[i][w] = 0;
    foreach (sh_v[i]) sh_v[i] = 0;
    foreach (li_v[i]) li_v[i] = 0;
    foreach (cam_w[i]) cam_w[i] = '0;

    step(0, opNop, 0, 0, 0, 0, 0, 0, 1);
    step(0, opNop, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0);

    // camera write, latency 1, no busy window
    step(1, opCameraWr, 0, 0, 32'h3F80_0000, 0, 0, 0, 0);
    idle(0, 0);
    // shape RMW then an overlapping write that must be refused
    step(1, opShapeWr, 3, 1, 32'hDEAD_BEEF, 0, 3, 0, 0);
    step(1, opShapeWr, 3, 1, 32'h1234_5678, 0, 3, 0, 0);
    repeat (6) idle(3, 0);
    // render_busy refusal, out-of-range index and field
    step(1, opLightWr, 0, 0, 32'h0000_CAFE, 1, 3, 0, 0);
    repeat (3) idle(3, 0);
    step(1, opShapeWr, 16, 0, 32'h1111_1111, 0, 3, 0, 0);
    step(1, opShapeWr, 2, SHAPE_WORDS, 32'h2222_2222, 0, 2, 0, 0);
    repeat (3) idle(2, 0);

    // fill every word of both tables so reads become fully predictable
    for (int i = 0; i < NUM_SHAPES; i++)
      for (int w = 0; w < SHAPE_WORDS; w++) begin
        step(1, opShapeWr, i, w, $urandom(), 0, i, 0, 0);
        repeat (4) idle(i, 0);
      end
    for (int i = 0; i < NUM_LIGHTS; i++)
      for (int w = 0; w < LIGHT_WORDS; w++) begin
        step(1, opLightWr, i, w, $urandom(), 0, 0, i, 0);
        repeat (4) idle(0, i);
      end

    // back-to-back reads, clear, re-read
    for (int a = 0; a < 4; a++) idle(a, a);
    step(1, opClear, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 4; a++) idle(a, a);

    // reset in the middle of an RMW leaves the entry untouched
    step(1, opShapeWr, 5, 0, 32'hAAAA_5555, 0, 5, 0, 0);
    idle(5, 0);
    step(0, opNop, 0, 0, 0, 0, 5, 0, 1);
    repeat (4) idle(5, 0);

    for (int n = 0; n < 2500; n++) begin
      int p, idx, fld;
      bit v, rb, r;
      iType_t t;
      p = $urandom_range(0, 99);
      v = 1;
      if (p < 25) t = opShapeWr;
      else if (p < 40) t = opLightWr;
      else if (p < 50) t = opCameraWr;
      else if (p < 53) t = opClear;
      else if (p < 60) t = opFrame;
      else if (p < 63) t = opRender;
      else begin t = opNop; v = 0; end
      idx = (t == opLightWr) ? $urandom_range(0, 5) : $urandom_range(0, 17);
      fld = $urandom_range(0, 6);
      rb  = ($urandom_range(0, 9) == 0);
      r   = ($urandom_range(0, 299) == 0);
      if (r) v = 0;
      step(v, t, idx, fld, $urandom(), rb, $urandom_range(0, NUM_SHAPES - 1),
           $urandom_range(0, NUM_LIGHTS - 1), r);
    end
    repeat (4) idle(0, 0);
    repeat (4) @(posedge clk);

    left = q_rdy.size() + q_err.size() + q_cam.size() + q_sv.size() + q_sd.size() + q_lv.size() + q_ld.size();
    if (left != 0) begin
      n_checks += left;
      $display("FAIL scoreboard_drain left=%0d required=0", left);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
